mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 52 +++++
 rtl/mdu_ctrl.sv | 142 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state encoding and a small op-classification helper.
// Optional feature macro used by mdu_ctrl: MDU_ABORT_EN.
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops 0-3 are the multi-cycle arithmetic ops.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: 64-bit products for MULT/MULTU and
// {remainder, quotient} for DIV/DIVU, plus a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] b_mag_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;

  // Signed division runs on magnitudes so 0x80000000 / -1 falls out as
  // 0x80000000 rem 0 without overflow; a zero divisor is replaced by 1 so
  // the datapath never produces X (the result is discarded anyway).
  always_comb begin
    mul_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    mul_u      = {32'd0, a} * {32'd0, b};
    a_mag      = a[31] ? (32'd0 - a) : a;
    b_mag      = b[31] ? (32'd0 - b) : b;
    b_safe     = (b == 32'd0) ? 32'd1 : b;
    b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq         = a / b_safe;
    ur         = a % b_safe;
    sq_mag     = a_mag / b_mag_safe;
    sr_mag     = a_mag % b_mag_safe;
    sq         = (a[31] ^ b[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr         = a[31] ? (32'd0 - sr_mag) : sr_mag;
    div_zero   = ((op == OP_DIV) || (op == OP_DIVU)) && (b == 32'd0);
    case (op)
      OP_MULT:  result = mul_s;
      OP_MULTU: result = mul_u;
      OP_DIV:   result = {sr, sq};
      OP_DIVU:  result = {ur, uq};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS-style multiply/divide unit controller: IDLE/BUSY FSM, latency
// counter, pending result registers and architectural HI/LO.
// The result is computed at Start and held pending; HI/LO commit on the
// edge that ends the last Busy cycle.
// Optional feature: define MDU_ABORT_EN to add an Abort input.
// Handshake: Start is a single-cycle request sampled on the rising edge;
// it is accepted only in IDLE (and, with MDU_ABORT_EN, only when Abort is
// low); StallReq = Start | Busy tells the hazard unit to hold the pipe.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RdHi,
`ifdef MDU_ABORT_EN
  input  logic        Abort,
`endif
  output logic        Busy,
  output logic        StallReq,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out,
  output mdu_state_e  dbg_state
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;

  logic [63:0]      arith_res;
  logic             arith_dz;
  logic             abort_w;

`ifdef MDU_ABORT_EN
  assign abort_w = Abort;
`else
  assign abort_w = 1'b0;
`endif

  mdu_arith u_arith (
    .a        (A),
    .b        (B),
    .op       (Op),
    .result   (arith_res),
    .div_zero (arith_dz)
  );

  // Next-state: accept ops in IDLE, count down in BUSY, commit at the end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && !abort_w) begin
          if (is_long_op(Op)) begin
            pend_hi_d = arith_res[63:32];
            pend_lo_d = arith_res[31:0];
            pend_dz_d = arith_dz;
            cnt_d     = is_mult_op(Op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d   = ST_BUSY;
          end else if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_BUSY: begin
        // Abort outranks the final-cycle commit; Start is ignored here.
        if (abort_w) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_BUSY);
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign Busy      = busy_q;
  assign StallReq  = Start | busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign Out       = RdHi ? hi_q : lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized
// traffic, checked against a cycle-level behavioural model of HI/LO.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start_r = 1'b0;
  logic [2:0]  op_r = 3'd0;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  logic        rdhi_r = 1'b0;
  logic        abort_r = 1'b0;

  logic        busy_o, stall_o;
  logic [31:0] hi_o, lo_o, out_o;
  mdu_state_e  state_o;

  mdu_ctrl #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (start_r),
    .Op        (op_r),
    .A         (a_r),
    .B         (b_r),
    .RdHi      (rdhi_r),
`ifdef MDU_ABORT_EN
    .Abort     (abort_r),
`endif
    .Busy      (busy_o),
    .StallReq  (stall_o),
    .HI        (hi_o),
    .LO        (lo_o),
    .Out       (out_o),
    .dbg_state (state_o)
  );

  // scoreboard counters and model state
  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi, m_lo;
  int          m_left;        // busy cycles remaining
  logic [63:0] m_pend;        // {hi, lo} to commit
  logic        m_skip;        // divide by zero: keep HI/LO
  logic [63:0] exp_q[$];      // committed results, in order
  logic [63:0] saved;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference arithmetic from the ISA definition using wide integers.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return 64'(ua * ub);
      OP_DIV: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_left = 0; m_pend = '0; m_skip = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT saw.
  task automatic model_edge();
    if (m_left > 0) begin
      if (abort_r) m_left = 0;
      else begin
        if (m_left == 1 && !m_skip) begin
          m_hi = m_pend[63:32];
          m_lo = m_pend[31:0];
          exp_q.push_back(m_pend);
        end
        m_left--;
      end
    end else if (start_r && !abort_r) begin
      if (op_r <= 3'd3) begin
        m_skip = (op_r >= 3'd2) && (b_r == 32'd0);
        m_pend = m_skip ? 64'd0 : ref_result(op_r, a_r, b_r);
        m_left = (op_r <= 3'd1) ? MULT_CYC : DIV_CYC;
      end else if (op_r == 3'd4) m_hi = a_r;
      else if (op_r == 3'd5) m_lo = a_r;
    end
  endtask

  // Driver: apply inputs after a falling edge, check the combinational
  // outputs, clock once, then check registered outputs on the next fall.
  task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rh, input logic ab);
    logic [63:0] popped;
    start_r = st; op_r = op; a_r = a; b_r = b; rdhi_r = rh;
`ifdef MDU_ABORT_EN
    abort_r = ab;
`else
    abort_r = 1'b0 & ab;
`endif
    #1;
    check("stallreq", 64'(stall_o), 64'(st | (m_left > 0)));
    check("out", 64'(out_o), 64'(rh ? m_hi : m_lo));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("busy", 64'(busy_o), 64'(m_left > 0));
    check("state", 64'(state_o), 64'((m_left > 0) ? ST_BUSY : ST_IDLE));
    check("hi", 64'(hi_o), 64'(m_hi));
    check("lo", 64'(lo_o), 64'(m_lo));
    if (exp_q.size() > 0) begin
      popped = exp_q.pop_front();
      check("commit", {hi_o, lo_o}, popped);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, $urandom, $urandom, i[0], 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int busy_cnt;

  initial begin
    model_reset();
    // reset values while held in reset
    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_state", 64'(state_o), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    // MULT 3 * -2, counting Busy cycles explicitly
    cycle(1'b1, OP_MULT, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy_o) busy_cnt++;
      idle(1);
    end
    check("mult_busy_len", 64'(busy_cnt), 64'd5);
    check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);

    // MULTU 0xFFFFFFFF * 2
    cycle(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(MULT_CYC);
    check("multu_hi", 64'(hi_o), 64'h1);
    check("multu_lo", 64'(lo_o), 64'hFFFF_FFFE);

    // DIV -7 / 2
    cycle(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DIV_CYC - 1);
    check("div_pre_busy", 64'(busy_o), 64'd1);
    idle(1);
    check("div_lo", 64'(lo_o), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi_o), 64'hFFFF_FFFF);

    // MTHI then DIVU by zero
    cycle(1'b1, OP_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    check("mthi_busy", 64'(busy_o), 64'd0);
    saved = {32'd0, lo_o};
    cycle(1'b1, OP_DIVU, 32'd99, 32'd0, 1'b1, 1'b0);
    idle(DIV_CYC);
    check("dz_hi", 64'(hi_o), 64'h1234_5678);
    check("dz_lo", 64'(lo_o), saved);
    rdhi_r = 1'b1; #1;
    check("dz_out", 64'(out_o), 64'h1234_5678);

    // signed overflow case
    cycle(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DIV_CYC);
    check("ovf_lo", 64'(lo_o), 64'h8000_0000);
    check("ovf_hi", 64'(hi_o), 64'h0);

    // Start DIV during busy cycle 2 of MULT is ignored
    cycle(1'b1, OP_MULT, 32'd7, 32'd6, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, OP_DIV, 32'd100, 32'd3, 1'b0, 1'b0);
    idle(MULT_CYC - 2);
    check("ign_busy", 64'(busy_o), 64'd0);
    check("ign_lo", 64'(lo_o), 64'd42);

    // reserved ops and MTLO
    cycle(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    check("rsv_lo", 64'(lo_o), 64'd42);
    cycle(1'b1, OP_MTLO, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
    check("mtlo_lo", 64'(lo_o), 64'hCAFE_0001);

`ifdef MDU_ABORT_EN
    // Abort in busy cycle 3, then Abort together with MTHI in IDLE
    saved = {hi_o, lo_o};
    cycle(1'b1, OP_DIV, 32'd50, 32'd7, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_hilo", {hi_o, lo_o}, saved);
    cycle(1'b1, OP_MTHI, 32'h5555_AAAA, 32'd0, 1'b1, 1'b1);
    check("abort_mthi", 64'(hi_o), saved[63:32]);
`endif

    // asynchronous reset in busy cycle 3 of DIV
    cycle(1'b1, OP_DIV, 32'd1000, 32'd9, 1'b0, 1'b0);
    idle(2);
    start_r = 1'b0; abort_r = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_hi", 64'(hi_o), 64'd0);
    check("arst_lo", 64'(lo_o), 64'd0);
    check("arst_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, OP_MTLO, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b0);
    check("first_start", 64'(lo_o), 64'h0BAD_F00D);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), rand_operand(),
            rand_operand(), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    idle(DIV_CYC + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
